// File: rtl/rotor_stepper.sv
// -----------------------------------------------------------------------------
// rotor_stepper
//
// Stepping controller for a three-rotor (left/middle/right) cipher chain.
// Each accepted keypress advances the rotor positions by the odometer
// turnover rule, including the middle-rotor double step. After stepping, the
// controller waits SETTLE_CYCLES cycles so the combinational rotor/reflector
// path can settle on the new positions. It then strobes valid for one cycle.
//
// Parameters
//   NOTCH_R        right-rotor turnover position; the middle rotor steps when
//                  the right rotor is at this position
//   NOTCH_M        middle-rotor turnover position; the left and middle rotors
//                  step when the middle rotor is at this position
//   SETTLE_CYCLES  cycles (>=1) of settle time between the step and valid
//
// Ports
//   clk        in   1  clock; all state changes on the rising edge
//   rst        in   1  synchronous, active-high reset
//   key_valid  in   1  keypress request; accepted when key_valid & ready
//   ready      out  1  high in IDLE only
//   load       in   1  load initial positions; highest priority, any state
//   load_l     in   5  left position to load (values >=26 load 0)
//   load_m     in   5  middle position to load (values >=26 load 0)
//   load_r     in   5  right position to load (values >=26 load 0)
//   pos_l      out  5  left rotor position, 0..25, registered
//   pos_m      out  5  middle rotor position, 0..25, registered
//   pos_r      out  5  right rotor position, 0..25, registered
//   valid      out  1  one-cycle strobe: positions stepped and path settled
// -----------------------------------------------------------------------------
module rotor_stepper #(
   parameter int NOTCH_R       = 21,
   parameter int NOTCH_M       = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   output logic       ready,
   input  logic       load,
   input  logic [4:0] load_l,
   input  logic [4:0] load_m,
   input  logic [4:0] load_r,
   output logic [4:0] pos_l,
   output logic [4:0] pos_m,
   output logic [4:0] pos_r,
   output logic       valid
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [4:0] NOTCH_R_V = 5'(NOTCH_R);
   localparam logic [4:0] NOTCH_M_V = 5'(NOTCH_M);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [4:0]       pos_l_n, pos_m_n, pos_r_n;

   // Increment modulo 26.
   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p >= 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   // Out-of-range load values collapse to position 0.
   function automatic logic [4:0] clamp26(input logic [4:0] p);
      return (p > 5'd25) ? 5'd0 : p;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         pos_l <= 5'd0;
         pos_m <= 5'd0;
         pos_r <= 5'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pos_l <= pos_l_n;
         pos_m <= pos_m_n;
         pos_r <= pos_r_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pos_l_n = pos_l;
      pos_m_n = pos_m;
      pos_r_n = pos_r;
      ready   = (state == IDLE);
      valid   = (state == DONE);

      if (load) begin
         // Load overrides everything: it aborts any in-flight step (so no
         // valid follows) and swallows a keypress on the same edge.
         pos_l_n = clamp26(load_l);
         pos_m_n = clamp26(load_m);
         pos_r_n = clamp26(load_r);
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid) begin
                  // All three decisions use the pre-step positions. The middle
                  // rotor also steps when it sits on its own notch; this is
                  // the double step.
                  pos_r_n = inc26(pos_r);
                  if ((pos_r == NOTCH_R_V) || (pos_m == NOTCH_M_V))
                     pos_m_n = inc26(pos_m);
                  if (pos_m == NOTCH_M_V)
                     pos_l_n = inc26(pos_l);
                  state_n = SETTLE;
                  cnt_n   = SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (cnt == '0)
                  state_n = DONE;
               else
                  cnt_n = cnt - 1'b1;
            end
            DONE: begin
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotor_stepper.sv
module tb_rotor_stepper;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic       ready;
   logic       load;
   logic [4:0] load_l, load_m, load_r;
   logic [4:0] pos_l, pos_m, pos_r;
   logic       valid;

   int checks;
   int errors;

   rotor_stepper #(
      .NOTCH_R      (21),
      .NOTCH_M      (4),
      .SETTLE_CYCLES(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid),
      .ready    (ready),
      .load     (load),
      .load_l   (load_l),
      .load_m   (load_m),
      .load_r   (load_r),
      .pos_l    (pos_l),
      .pos_m    (pos_m),
      .pos_r    (pos_r),
      .valid    (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Positions are packed as {l,m,r}, 5 bits each.
   task automatic check_pos(input string tag, input int l, input int m, input int r);
      check(tag, {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'(l), 5'(m), 5'(r)});
   endtask

   // Advance one rising edge; the bench samples and drives 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int l, input int m, input int r);
      load   = 1'b1;
      load_l = 5'(l);
      load_m = 5'(m);
      load_r = 5'(r);
      tick();
      load   = 1'b0;
   endtask

   // Full keypress: accept, settle, valid, back to idle (SETTLE_CYCLES=1).
   task automatic press(input string tag, input int l, input int m, input int r);
      check({tag, "_ready_pre"}, 32'(ready), 32'd1);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check_pos({tag, "_pos"}, l, m, r);
      check({tag, "_ready_settle"}, 32'(ready), 32'd0);
      check({tag, "_valid_settle"}, 32'(valid), 32'd0);
      tick();
      check({tag, "_valid_done"}, 32'(valid), 32'd1);
      check({tag, "_ready_done"}, 32'(ready), 32'd0);
      tick();
      check({tag, "_valid_idle"}, 32'(valid), 32'd0);
      check({tag, "_ready_idle"}, 32'(ready), 32'd1);
      check_pos({tag, "_pos_hold"}, l, m, r);
   endtask

   initial begin
      int exp_r[6];
      int exp_v[6];
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      key_valid = 1'b0;
      load      = 1'b0;
      load_l    = '0;
      load_m    = '0;
      load_r    = '0;

      // 1: reset and idle
      tick();
      tick();
      rst = 1'b0;
      check_pos("rst_pos", 0, 0, 0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_valid", 32'(valid), 32'd0);
      end
      check_pos("idle_pos", 0, 0, 0);

      // 2: basic stepping and right-notch carry
      do_load(0, 0, 20);
      check_pos("load1", 0, 0, 20);
      press("k1", 0, 0, 21);
      press("k2", 0, 1, 22);

      // 3: double step
      do_load(0, 3, 21);
      press("ds1", 0, 4, 22);
      press("ds2", 1, 5, 23);
      press("ds3", 1, 5, 24);

      // 4: wrap-around
      do_load(25, 25, 25);
      press("wrap1", 25, 25, 0);
      do_load(25, 4, 21);
      press("wrap2", 0, 5, 22);

      // 5: load during SETTLE aborts the step
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check_pos("abort_step", 0, 5, 23);
      check("abort_in_settle", 32'(ready), 32'd0);
      do_load(7, 8, 9);
      check_pos("abort_pos", 7, 8, 9);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_valid", 32'(valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_no_valid", 32'(valid), 32'd0);
      end

      // 5b: key held high, one step per accept only
      exp_r = '{10, 10, 10, 11, 11, 11};
      exp_v = '{0, 1, 0, 0, 1, 0};
      key_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("held_r", 32'(pos_r), 32'(exp_r[i]));
         check("held_valid", 32'(valid), 32'(exp_v[i]));
      end
      key_valid = 1'b0;
      check_pos("held_pos", 7, 8, 11);

      // load on the same edge as a keypress: key dropped
      key_valid = 1'b1;
      do_load(1, 1, 1);
      key_valid = 1'b0;
      check_pos("load_key_pos", 1, 1, 1);
      check("load_key_ready", 32'(ready), 32'd1);

      // 6: out-of-range load values
      do_load(30, 2, 26);
      check_pos("clamp", 0, 2, 0);

      // reset while in DONE
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      check_pos("pre_rst_pos", 0, 2, 1);
      tick();
      check("pre_rst_valid", 32'(valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_done_valid", 32'(valid), 32'd0);
      check("rst_done_ready", 32'(ready), 32'd1);
      check_pos("rst_done_pos", 0, 0, 0);

      // reset beats a simultaneous load
      rst = 1'b1;
      do_load(5, 6, 7);
      rst = 1'b0;
      check_pos("rst_vs_load", 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
